// File: rtl/fm_pkg.sv
// fm_pkg: shared constants and helpers for the FM tone path.
//   PHASE_W/LUT_AW/AMP_SHIFT/OUT_W : default widths of the DDS tone source
//   DEF_FTW                        : tuning word for a 500-sample sine period
//   sample_t                       : signed output sample type
//   quarter_sine()                 : one quarter-wave table entry, elaboration-time integer math
package fm_pkg;

   localparam int PHASE_W   = 32;
   localparam int LUT_AW    = 8;
   localparam int AMP_SHIFT = 20;
   localparam int OUT_W     = 32;

   localparam logic [PHASE_W-1:0] DEF_FTW = 32'd8589935;

   typedef logic signed [OUT_W-1:0] sample_t;

   // pi in Q30 fixed point
   localparam longint PI_Q30 = 64'sd3373259426;

   // Entry k = round((2^amp_shift-1) * sin(pi/2 * (k+0.5) / 2^lut_aw)).
   // The angle is formed in Q30 and sin() is a 15th-order Taylor series; the
   // residual error is a few thousandths of an output LSB.
   function automatic longint quarter_sine(input int k, input int lut_aw, input int amp_shift);
      longint x;
      longint x2;
      longint term;
      longint acc;
      longint full;
      x    = (PI_Q30 * longint'(2 * k + 1) + (longint'(1) <<< (lut_aw + 1))) >>> (lut_aw + 2);
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n <= 7; n++) begin
         term = ((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         if (n % 2 == 1) acc = acc - term;
         else            acc = acc + term;
      end
      full = (longint'(1) <<< amp_shift) - 1;
      return (acc * full + (longint'(1) <<< 29)) >>> 30;
   endfunction

endpackage

// File: rtl/fm_sine_rom.sv
// fm_sine_rom: registered quarter-wave sine ROM.
//   clock  : rising-edge clock
//   en_i   : 1 = capture the entry at addr_i, 0 = hold the last output
//   addr_i : quarter-wave address (0 .. 2^ADDR_W-1)
//   data_o : unsigned magnitude, one cycle after the address is presented
module fm_sine_rom #(
   parameter int ADDR_W = fm_pkg::LUT_AW,
   parameter int DATA_W = fm_pkg::AMP_SHIFT
) (
   input  logic              clock,
   input  logic              en_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0] data_o
);
   import fm_pkg::*;

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] rom_w [DEPTH];
   logic [DATA_W-1:0] data_q;

   // Each entry is a localparam so the table is fixed at elaboration.
   for (genvar k = 0; k < DEPTH; k++) begin : g_entry
      localparam logic [DATA_W-1:0] ENTRY = DATA_W'(quarter_sine(k, ADDR_W, DATA_W));
      assign rom_w[k] = ENTRY;
   end

   always_ff @(posedge clock) begin
      if (en_i) begin
         data_q <= rom_w[addr_i];
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/fm_tone_source.sv
// fm_tone_source: DDS sine generator (phase accumulator + quarter-wave ROM).
//   clock         : single clock, all state on rising edge
//   reset         : synchronous, active-high
//   io_en         : 1 = issue a new phase each unstalled cycle
//   io_sync       : clear phase to 0 and flush all in-flight samples
//   io_ftw_valid  : load io_ftw_bits into the tuning register
//   io_ftw_bits   : unsigned frequency tuning word
//   io_out_ready  : consumer accepts the presented sample
//   io_out_valid  : sample valid (held until accepted)
//   io_out_value  : signed sample, |value| <= 2^AMP_SHIFT-1
// Pipeline: phase issue -> fold -> ROM read -> sign/output register,
// three cycles from issue to io_out_valid.
module fm_tone_source #(
   parameter int                 PHASE_W   = fm_pkg::PHASE_W,
   parameter int                 LUT_AW    = fm_pkg::LUT_AW,
   parameter int                 AMP_SHIFT = fm_pkg::AMP_SHIFT,
   parameter int                 OUT_W     = fm_pkg::OUT_W,
   parameter logic [PHASE_W-1:0] DEF_FTW   = PHASE_W'(fm_pkg::DEF_FTW)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               io_en,
   input  logic               io_sync,
   input  logic               io_ftw_valid,
   input  logic [PHASE_W-1:0] io_ftw_bits,
   input  logic               io_out_ready,
   output logic               io_out_valid,
   output logic [OUT_W-1:0]   io_out_value
);
   import fm_pkg::*;

   localparam int PAD_W = OUT_W - AMP_SHIFT;

   // Magnitude is positive and below 2^AMP_SHIFT, so zero-extension then
   // negation can never overflow OUT_W.
   function automatic logic signed [OUT_W-1:0] apply_sign(input logic [AMP_SHIFT-1:0] mag,
                                                          input logic                 neg);
      logic signed [OUT_W-1:0] ext;
      ext = $signed({{PAD_W{1'b0}}, mag});
      return neg ? -ext : ext;
   endfunction

   logic [PHASE_W-1:0]      phase_q, phase_d;
   logic [PHASE_W-1:0]      ftw_q, ftw_d;
   logic                    stall, issue, rom_en;
   logic                    vld_p1_q, vld_p1_d;
   logic                    vld_p2_q, vld_p2_d;
   logic                    vld_p3_q, vld_p3_d;
   logic [1:0]              quad_p0;
   logic [LUT_AW-1:0]       addr_raw_p0, addr_p0;
   logic [1:0]              quad_p1_q, quad_p2_q;
   logic [LUT_AW-1:0]       addr_p1_q;
   logic [AMP_SHIFT-1:0]    mag_p2;
   logic signed [OUT_W-1:0] value_p3_q;

   // A presented but unaccepted sample freezes the whole pipe.
   assign stall  = vld_p3_q && !io_out_ready;
   assign issue  = io_en && !stall;
   assign rom_en = !stall;

   always_comb begin
      phase_d  = phase_q;
      ftw_d    = ftw_q;
      vld_p1_d = vld_p1_q;
      vld_p2_d = vld_p2_q;
      vld_p3_d = vld_p3_q;
      if (io_ftw_valid) begin
         ftw_d = io_ftw_bits;
      end
      // sync wins over stall and over a same-cycle issue
      if (io_sync) begin
         phase_d  = '0;
         vld_p1_d = 1'b0;
         vld_p2_d = 1'b0;
         vld_p3_d = 1'b0;
      end else if (!stall) begin
         if (issue) begin
            phase_d = phase_q + ftw_q;
         end
         vld_p1_d = issue;
         vld_p2_d = vld_p1_q;
         vld_p3_d = vld_p2_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q  <= '0;
         ftw_q    <= DEF_FTW;
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         ftw_q    <= ftw_d;
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         vld_p3_q <= vld_p3_d;
      end
   end

   // ---- p0 -> p1: fold phase into quadrant + quarter-wave address ----
   // Odd quadrants run the table backwards; the half-bin offset in the table
   // makes ~addr the exact mirror.
   assign quad_p0     = phase_q[PHASE_W-1 -: 2];
   assign addr_raw_p0 = phase_q[PHASE_W-3 -: LUT_AW];
   assign addr_p0     = quad_p0[0] ? ~addr_raw_p0 : addr_raw_p0;

   always_ff @(posedge clock) begin
      if (!stall) begin
         quad_p1_q <= quad_p0;
         addr_p1_q <= addr_p0;
         quad_p2_q <= quad_p1_q;
      end
   end

   // ---- p1 -> p2: registered ROM read ----
   fm_sine_rom #(
      .ADDR_W(LUT_AW),
      .DATA_W(AMP_SHIFT)
   ) u_rom (
      .clock  (clock),
      .en_i   (rom_en),
      .addr_i (addr_p1_q),
      .data_o (mag_p2)
   );

   // ---- p2 -> p3: apply sign for the lower half-cycle, output register ----
   always_ff @(posedge clock) begin
      if (reset) begin
         value_p3_q <= '0;
      end else if (!stall) begin
         value_p3_q <= apply_sign(mag_p2, quad_p2_q[1]);
      end
   end

   assign io_out_valid = vld_p3_q;
   assign io_out_value = value_p3_q;

endmodule
